hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Stall and flush controller for the 5-stage pipeline. It handles the hazards that EX-stage forwarding cannot resolve:
  - load-use;
  - branch operands that are resolved in ID but not yet available;
  - taken-branch squash.
- It drives the PC and IF/ID write enables and the bubble/flush controls.
- It keeps saturating stall/flush performance counters and a stuck-stall watchdog.

Parameters:
- CNT_W, 16, width of the Stall_Count and Flush_Count saturating counters.
- MAX_STALL, 3, maximum legal consecutive stall cycles before Hazard_Error is set.

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- MemRead_ID_EX  in  1  instruction in EX is a load.
- RegWrite_ID_EX  in  1  instruction in EX writes a register.
- Rd_ID_EX  in  5  destination register of the instruction in EX, after the RegDst mux.
- MemRead_EX_MEM  in  1  instruction in MEM is a load.
- Rd_EX_MEM  in  5  destination register of the instruction in MEM.
- Rs_IF_ID  in  5  Rs field of the instruction in ID.
- Rt_IF_ID  in  5  Rt field of the instruction in ID.
- Uses_Rt_ID  in  1  instruction in ID reads Rt (R-type, store, branch).
- Branch_ID  in  1  instruction in ID is a conditional branch.
- Branch_Taken_ID  in  1  ID-stage comparator result; valid only when Branch_ID=1.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register load enable.
- ID_EX_Flush  out  1  insert a bubble (zero control) into ID/EX.
- IF_ID_Flush  out  1  zero the IF/ID register (squash fetched instruction).
- Stalling  out  1  registered; high while the FSM is in STALL.
- Stall_Count  out  CNT_W  saturating count of stall cycles.
- Flush_Count  out  CNT_W  saturating count of taken-branch flushes.
- Hazard_Error  out  1  sticky watchdog flag.

Behaviour:
- Match terms: a register matches an ID source when it is nonzero and equals Rs_IF_ID, or equals Rt_IF_ID with Uses_Rt_ID=1.
- Hazard conditions, evaluated combinationally in the same cycle:
  - load_use = MemRead_ID_EX and Rd_ID_EX matches.
  - br_ex = Branch_ID and RegWrite_ID_EX and Rd_ID_EX matches.
  - br_mem = Branch_ID and MemRead_EX_MEM and Rd_EX_MEM matches.
  - stall_req = load_use or br_ex or br_mem.
- Consequence: a load followed immediately by a dependent branch stalls 2 cycles (br_ex, then br_mem). An ALU op followed by a dependent branch stalls 1 cycle.
- Control outputs are combinational with this priority: Reset > stall_req > taken branch > run.
  - Reset=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=1.
  - stall_req: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0. Branch_Taken_ID is ignored because the operands are stale.
  - Branch_ID and Branch_Taken_ID, no stall: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=1.
  - Otherwise: PC_Write=1, IF_ID_Write=1, both flushes 0.
- FSM, two states, registered:
  - RUN to STALL when stall_req.
  - STALL stays in STALL while stall_req; returns to RUN when stall_req=0.
  - Stalling = (state==STALL).
  - run_len is a 3-bit or wider register: cleared in RUN, incremented each cycle in STALL while stall_req, and saturates.
- Watchdog: if stall_req=1 and run_len==MAX_STALL on the same edge (i.e. the stall run exceeds MAX_STALL cycles), set Hazard_Error. It stays set until Reset. The pipeline is not altered by the flag.
- Counters:
  - Stall_Count increments on every edge with stall_req=1.
  - Flush_Count increments on every edge with a taken-branch flush.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous): state=RUN, run_len=0, Stalling=0, Stall_Count=0, Flush_Count=0, Hazard_Error=0.
  - A Reset asserted mid-stall aborts the stall run. No counter increment occurs on the reset edge.
- Register 0 never causes a hazard, whatever the MemRead/RegWrite values.

Decomposition:
- Shared pipeline package:
  - REG_ZERO constant (5'd0);
  - FSM state encoding HZ_RUN/HZ_STALL;
  - CNT_W default.
- One natural sub-module, sat_counter (parameterised width; increment enable; synchronous reset), instantiated twice for Stall_Count and Flush_Count.

Test Plan:
- Load-use: lw $2 in EX (MemRead_ID_EX=1, Rd_ID_EX=2), add with Rs_IF_ID=2 in ID -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; Stall_Count=1; next cycle all run values, Stalling falls.
- Load then branch: Rd_ID_EX=5 load, beq with Rs_IF_ID=5 -> two consecutive stall cycles (br_ex then br_mem); Stall_Count=2; then Branch_Taken_ID=1 -> IF_ID_Flush=1, Flush_Count=1.
- Zero register and Uses_Rt_ID: load to $0 with Rs_IF_ID=0 -> no stall. Load to $7 with Rt_IF_ID=7 and Uses_Rt_ID=0 -> no stall.
- Stall beats branch: stall_req=1 with Branch_Taken_ID=1 -> IF_ID_Flush=0, Flush_Count unchanged.
- Watchdog: stall_req held 4 cycles with MAX_STALL=3 -> Hazard_Error=1 from the 4th edge, stays 1 after stall_req drops, clears only on Reset.
- Saturation and reset: CNT_W=4, force 20 stall cycles -> Stall_Count=15. Reset asserted mid-stall -> next edge all registered outputs 0 and state RUN.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard detection unit: register-zero
// constant, stall FSM encoding and default performance-counter width.
package hazard_detection_unit_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         HZ_CNT_W = 16;

  typedef enum logic {
    HZ_RUN   = 1'b0,
    HZ_STALL = 1'b1
  } hz_state_e;
endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and ID-branch
// operand stalls, taken-branch squash, perf counters and a stuck-stall watchdog.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int CNT_W     = HZ_CNT_W,
  parameter int MAX_STALL = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MemRead_ID_EX,
  input  logic             RegWrite_ID_EX,
  input  logic [4:0]       Rd_ID_EX,
  input  logic             MemRead_EX_MEM,
  input  logic [4:0]       Rd_EX_MEM,
  input  logic [4:0]       Rs_IF_ID,
  input  logic [4:0]       Rt_IF_ID,
  input  logic             Uses_Rt_ID,
  input  logic             Branch_ID,
  input  logic             Branch_Taken_ID,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Flush,
  output logic             IF_ID_Flush,
  output logic             Stalling,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count,
  output logic             Hazard_Error
);
  localparam int RL_W = (MAX_STALL < 7) ? 3 : $clog2(MAX_STALL + 2);

  hz_state_e        state_q, state_d;
  logic [RL_W-1:0]  run_len_q, run_len_d;
  logic             err_q, err_d;
  logic             load_use, br_ex, br_mem, stall_req, br_flush;

  function automatic logic src_match(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rt);
    return (rd != REG_ZERO) && ((rd == rs) || (use_rt && (rd == rt)));
  endfunction

  assign load_use  = MemRead_ID_EX && src_match(Rd_ID_EX, Rs_IF_ID, Rt_IF_ID, Uses_Rt_ID);
  assign br_ex     = Branch_ID && RegWrite_ID_EX &&
                     src_match(Rd_ID_EX, Rs_IF_ID, Rt_IF_ID, Uses_Rt_ID);
  assign br_mem    = Branch_ID && MemRead_EX_MEM &&
                     src_match(Rd_EX_MEM, Rs_IF_ID, Rt_IF_ID, Uses_Rt_ID);
  assign stall_req = load_use || br_ex || br_mem;
  // Stale operands during a stall make the comparator result meaningless.
  assign br_flush  = Branch_ID && Branch_Taken_ID && !stall_req;

  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Flush = 1'b0;
    IF_ID_Flush = 1'b0;
    if (Reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      IF_ID_Flush = 1'b1;
    end else if (stall_req) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (br_flush) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // run_len counts consecutive stall edges, so it reaches MAX_STALL on the
  // edge that would begin stall cycle MAX_STALL+1.
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    err_d     = err_q;
    if (stall_req) begin
      state_d = HZ_STALL;
      if (run_len_q == RL_W'(MAX_STALL)) err_d = 1'b1;
      if (run_len_q != {RL_W{1'b1}}) run_len_d = run_len_q + RL_W'(1);
    end else begin
      state_d   = HZ_RUN;
      run_len_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= HZ_RUN;
      run_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      err_q     <= err_d;
    end
  end

  assign Stalling     = (state_q == HZ_STALL);
  assign Hazard_Error = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (Clk),
    .rst_i (Reset),
    .inc_i (stall_req),
    .cnt_o (Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (Clk),
    .rst_i (Reset),
    .inc_i (br_flush),
    .cnt_o (Flush_Count)
  );
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: table of combinational control vectors plus
// hand sequences for stall runs, watchdog, saturation and mid-stall reset.
module tb_hazard_detection_unit;
  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 3;

  logic             Clk = 1'b0;
  logic             Reset, MemRead_ID_EX, RegWrite_ID_EX, MemRead_EX_MEM;
  logic [4:0]       Rd_ID_EX, Rd_EX_MEM, Rs_IF_ID, Rt_IF_ID;
  logic             Uses_Rt_ID, Branch_ID, Branch_Taken_ID;
  logic             PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, Stalling, Hazard_Error;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  hazard_detection_unit #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .Clk(Clk), .Reset(Reset),
    .MemRead_ID_EX(MemRead_ID_EX), .RegWrite_ID_EX(RegWrite_ID_EX), .Rd_ID_EX(Rd_ID_EX),
    .MemRead_EX_MEM(MemRead_EX_MEM), .Rd_EX_MEM(Rd_EX_MEM),
    .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .Uses_Rt_ID(Uses_Rt_ID),
    .Branch_ID(Branch_ID), .Branch_Taken_ID(Branch_Taken_ID),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Flush(ID_EX_Flush),
    .IF_ID_Flush(IF_ID_Flush), .Stalling(Stalling), .Stall_Count(Stall_Count),
    .Flush_Count(Flush_Count), .Hazard_Error(Hazard_Error)
  );

  typedef struct packed {
    logic       rst, mr_ex, rw_ex;
    logic [4:0] rd_ex;
    logic       mr_mem;
    logic [4:0] rd_mem, rs, rt;
    logic       urt, br, bt;
  } vin_t;

  // Control bits: {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush}
  typedef struct packed {
    vin_t       in;
    logic [3:0] ctl;
  } vec_t;

  typedef struct packed {
    logic             stalling, err;
    logic [CNT_W-1:0] scnt, fcnt;
  } regexp_t;

  regexp_t sb_q[$];

  // Reference state for the registered outputs
  logic             m_stalling, m_err;
  logic [CNT_W-1:0] m_scnt, m_fcnt;
  int               m_run;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vin_t mk(input logic rst, input logic mr_ex, input logic rw_ex,
                              input logic [4:0] rd_ex, input logic mr_mem,
                              input logic [4:0] rd_mem, input logic [4:0] rs,
                              input logic [4:0] rt, input logic urt, input logic br,
                              input logic bt);
    vin_t v;
    v = '{rst, mr_ex, rw_ex, rd_ex, mr_mem, rd_mem, rs, rt, urt, br, bt};
    return v;
  endfunction

  function automatic logic hit(input logic [4:0] rd, input vin_t v);
    if (rd == 5'd0) return 1'b0;
    return (rd == v.rs) || (v.urt && rd == v.rt);
  endfunction

  // Drive one cycle: push expected registered result, check the combinational
  // controls before the edge, then pop and compare after the edge.
  task automatic step(input vin_t v, input logic [3:0] ctl, input string name);
    logic    sreq, flush;
    regexp_t e, got;
    @(negedge Clk);
    Reset = v.rst; MemRead_ID_EX = v.mr_ex; RegWrite_ID_EX = v.rw_ex; Rd_ID_EX = v.rd_ex;
    MemRead_EX_MEM = v.mr_mem; Rd_EX_MEM = v.rd_mem; Rs_IF_ID = v.rs; Rt_IF_ID = v.rt;
    Uses_Rt_ID = v.urt; Branch_ID = v.br; Branch_Taken_ID = v.bt;
    sreq  = (v.mr_ex && hit(v.rd_ex, v)) || (v.br && v.rw_ex && hit(v.rd_ex, v)) ||
            (v.br && v.mr_mem && hit(v.rd_mem, v));
    flush = v.br && v.bt && !sreq;
    if (v.rst) begin
      m_stalling = 0; m_err = 0; m_scnt = 0; m_fcnt = 0; m_run = 0;
    end else begin
      if (sreq) begin
        if (m_run == MAX_STALL) m_err = 1;
        m_run++;
        if (m_scnt != '1) m_scnt++;
      end else m_run = 0;
      if (flush && m_fcnt != '1) m_fcnt++;
      m_stalling = sreq;
    end
    e = '{m_stalling, m_err, m_scnt, m_fcnt};
    sb_q.push_back(e);
    #1;
    check({name, ".ctl"}, 16'({PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush}), 16'(ctl));
    @(posedge Clk);
    #1;
    got = '{Stalling, Hazard_Error, Stall_Count, Flush_Count};
    e   = sb_q.pop_front();
    check({name, ".regs"}, 16'(got), 16'(e));
  endtask

  localparam logic [3:0] RUN = 4'b1100, STL = 4'b0010, BRF = 4'b1101, RST = 4'b0011;

  vin_t idle, lu2, lb5_ex, lb5_mem, btk;

  initial begin
    vec_t tbl[14];
    Reset = 1; MemRead_ID_EX = 0; RegWrite_ID_EX = 0; Rd_ID_EX = 0; MemRead_EX_MEM = 0;
    Rd_EX_MEM = 0; Rs_IF_ID = 0; Rt_IF_ID = 0; Uses_Rt_ID = 0; Branch_ID = 0; Branch_Taken_ID = 0;
    m_stalling = 0; m_err = 0; m_scnt = 0; m_fcnt = 0; m_run = 0;

    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu2     = mk(0, 1, 1, 2, 0, 0, 2, 3, 1, 0, 0);
    lb5_ex  = mk(0, 1, 1, 5, 0, 0, 5, 0, 1, 1, 0);
    lb5_mem = mk(0, 0, 0, 9, 1, 5, 5, 0, 1, 1, 0);
    btk     = mk(0, 0, 0, 0, 0, 0, 5, 0, 1, 1, 1);

    //                rst mr rw rd mm rdm rs rt urt br bt
    tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST};
    tbl[1]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RUN};
    tbl[2]  = '{mk(0, 1, 1, 2, 0, 0, 2, 0, 0, 0, 0), STL};  // load-use on Rs
    tbl[3]  = '{mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0), RUN};  // load to $0
    tbl[4]  = '{mk(0, 1, 1, 7, 0, 0, 1, 7, 0, 0, 0), RUN};  // Rt not read
    tbl[5]  = '{mk(0, 1, 1, 7, 0, 0, 1, 7, 1, 0, 0), STL};  // Rt read
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 3, 4, 1, 1, 1), BRF};  // taken branch
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 3, 4, 1, 1, 0), RUN};  // not taken
    tbl[8]  = '{mk(0, 0, 1, 4, 0, 0, 4, 0, 1, 1, 1), STL};  // br_ex beats taken
    tbl[9]  = '{mk(0, 0, 0, 0, 1, 6, 1, 6, 1, 1, 1), STL};  // br_mem on Rt
    tbl[10] = '{mk(0, 0, 1, 4, 0, 0, 4, 0, 1, 0, 0), RUN};  // ALU dep is forwarded
    tbl[11] = '{mk(0, 0, 0, 0, 1, 6, 6, 0, 1, 0, 0), RUN};  // MEM load, no branch
    tbl[12] = '{mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1), BRF};  // $0 never hazards
    tbl[13] = '{mk(1, 1, 1, 2, 0, 0, 2, 0, 1, 1, 1), RST};  // reset wins

    step(tbl[0].in, tbl[0].ctl, "reset");
    check("reset.cnt", 16'({Stall_Count, Flush_Count, Stalling, Hazard_Error}), 16'h0);
    for (int i = 0; i < 14; i++) step(tbl[i].in, tbl[i].ctl, $sformatf("vec%0d", i));

    // Load-use: one stall cycle then run
    step(lu2, STL, "lu.stall");
    check("lu.scnt", 16'(Stall_Count), 16'd1);
    check("lu.stalling", 16'(Stalling), 16'd1);
    step(idle, RUN, "lu.run");
    check("lu.fall", 16'(Stalling), 16'd0);

    // Load then dependent branch: two stalls, then taken squash
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST, "lb.rst");
    step(lb5_ex, STL, "lb.ex");
    step(lb5_mem, STL, "lb.mem");
    check("lb.scnt", 16'(Stall_Count), 16'd2);
    step(btk, BRF, "lb.taken");
    check("lb.fcnt", 16'(Flush_Count), 16'd1);
    check("lb.err", 16'(Hazard_Error), 16'd0);

    // Watchdog: 4th consecutive stall edge sets the flag
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST, "wd.rst");
    for (int i = 0; i < 3; i++) step(lu2, STL, $sformatf("wd.s%0d", i));
    check("wd.not_yet", 16'(Hazard_Error), 16'd0);
    step(lu2, STL, "wd.s3");
    check("wd.set", 16'(Hazard_Error), 16'd1);
    step(idle, RUN, "wd.hold");
    check("wd.sticky", 16'(Hazard_Error), 16'd1);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), RST, "wd.clr");
    check("wd.cleared", 16'(Hazard_Error), 16'd0);

    // Saturation, then reset mid-stall
    for (int i = 0; i < 20; i++) step(lu2, STL, $sformatf("sat%0d", i));
    check("sat.scnt", 16'(Stall_Count), 16'd15);
    step(mk(1, 1, 1, 2, 0, 0, 2, 0, 1, 0, 0), RST, "mid.rst");
    check("mid.regs", 16'({Stall_Count, Flush_Count, Stalling, Hazard_Error}), 16'h0);
    step(idle, RUN, "mid.run");
    check("mid.run_state", 16'(Stalling), 16'd0);

    // Flush counter saturation
    for (int i = 0; i < 17; i++) step(btk, BRF, $sformatf("fsat%0d", i));
    check("fsat.fcnt", 16'(Flush_Count), 16'd15);

    check("sb.empty", 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete (limit 100000 expected done)");
    $fatal(1);
  end
endmodule
